// File: rtl/rtc_secuencia_escribe_if.sv
`default_nettype none
// ============================================================================
// Module  : rtc_secuencia_escribe_if
// Brief   : Port-register side and RTC pin side of the RTC write sequencer.
// Revision: 1.0 - initial release
// ============================================================================
interface rtc_secuencia_escribe_if;
    logic       arranque;
    logic [7:0] direccion;
    logic [7:0] dato;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       cs_n;
    logic       a_d;
    logic       wr_n;
    logic       rd_n;
    logic       listo;
    logic [7:0] dato_leido;
    logic       error_rb;

    modport master (
        input  arranque, direccion, dato, bus_in,
        output bus_out, bus_oe, cs_n, a_d, wr_n, rd_n, listo, dato_leido, error_rb
    );

    modport slave (
        output arranque, direccion, dato, bus_in,
        input  bus_out, bus_oe, cs_n, a_d, wr_n, rd_n, listo, dato_leido, error_rb
    );
endinterface
`default_nettype wire

// File: rtl/rtc_secuencia_escribe.sv
`default_nettype none
// ============================================================================
// Module  : rtc_secuencia_escribe
// Brief   : One RTC write over the muxed address/data bus; optional read-back
//           verify phases enabled by defining RTC_READBACK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module rtc_secuencia_escribe #(
    parameter int T_FASE = 10,
    parameter int CNT_W  = 4
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    rtc_secuencia_escribe_if.master    bus
);
    localparam logic [3:0] c_IDLE  = 4'd0;
    localparam logic [3:0] c_A_SET = 4'd1;
    localparam logic [3:0] c_A_WR  = 4'd2;
    localparam logic [3:0] c_A_HLD = 4'd3;
    localparam logic [3:0] c_D_SET = 4'd4;
    localparam logic [3:0] c_D_WR  = 4'd5;
    localparam logic [3:0] c_D_HLD = 4'd6;
    localparam logic [3:0] c_R_SET = 4'd7;
    localparam logic [3:0] c_R_RD  = 4'd8;
    localparam logic [3:0] c_R_HLD = 4'd9;
    localparam logic [3:0] c_DONE  = 4'd10;

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(T_FASE - 1);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       bus_out_q, bus_out_d;
    logic             bus_oe_q, bus_oe_d;
    logic             cs_n_q, cs_n_d;
    logic             a_d_q, a_d_d;
    logic             wr_n_q, wr_n_d;
    logic             rd_n_q, rd_n_d;
    logic             listo_q, listo_d;
    logic [7:0]       dato_leido_q, dato_leido_d;
    logic             error_rb_q, error_rb_d;
    logic             w_start;
    logic             w_unused_bus_in;

    assign w_unused_bus_in = ^bus.bus_in;

    // Pins are registered from the next state so they move only on transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= c_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            bus_out_q    <= '0;
            bus_oe_q     <= 1'b0;
            cs_n_q       <= 1'b1;
            a_d_q        <= 1'b0;
            wr_n_q       <= 1'b1;
            rd_n_q       <= 1'b1;
            listo_q      <= 1'b0;
            dato_leido_q <= '0;
            error_rb_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            bus_out_q    <= bus_out_d;
            bus_oe_q     <= bus_oe_d;
            cs_n_q       <= cs_n_d;
            a_d_q        <= a_d_d;
            wr_n_q       <= wr_n_d;
            rd_n_q       <= rd_n_d;
            listo_q      <= listo_d;
            dato_leido_q <= dato_leido_d;
            error_rb_q   <= error_rb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        w_start = 1'b0;
        case (state_q)
            c_IDLE: begin
                if (bus.arranque) begin
                    w_start = 1'b1;
                    addr_d  = bus.direccion;
                    data_d  = bus.dato;
                    cnt_d   = '0;
                    state_d = c_A_SET;
                end
            end
            c_DONE: state_d = c_IDLE;
            default: begin
                if (cnt_q == c_LAST) begin
                    cnt_d = '0;
                    case (state_q)
                        c_A_SET: state_d = c_A_WR;
                        c_A_WR:  state_d = c_A_HLD;
                        c_A_HLD: state_d = c_D_SET;
                        c_D_SET: state_d = c_D_WR;
                        c_D_WR:  state_d = c_D_HLD;
`ifdef RTC_READBACK_EN
                        c_D_HLD: state_d = c_R_SET;
                        c_R_SET: state_d = c_R_RD;
                        c_R_RD:  state_d = c_R_HLD;
                        c_R_HLD: state_d = c_DONE;
`else
                        c_D_HLD: state_d = c_DONE;
`endif
                        default: state_d = c_IDLE;
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        bus_out_d = '0;
        bus_oe_d  = 1'b0;
        cs_n_d    = 1'b1;
        a_d_d     = 1'b0;
        wr_n_d    = 1'b1;
        rd_n_d    = 1'b1;
        listo_d   = 1'b0;
        case (state_d)
            c_A_SET, c_A_WR, c_A_HLD: begin
                cs_n_d    = 1'b0;
                bus_oe_d  = 1'b1;
                bus_out_d = addr_d;
                wr_n_d    = (state_d != c_A_WR);
            end
            c_D_SET, c_D_WR, c_D_HLD: begin
                cs_n_d    = 1'b0;
                bus_oe_d  = 1'b1;
                a_d_d     = 1'b1;
                bus_out_d = data_d;
                wr_n_d    = (state_d != c_D_WR);
            end
            c_R_SET, c_R_RD, c_R_HLD: begin
                cs_n_d = 1'b0;
                a_d_d  = 1'b1;
                rd_n_d = (state_d != c_R_RD);
            end
            c_DONE:  listo_d = 1'b1;
            default: ;
        endcase
`ifdef RTC_READBACK_EN
        dato_leido_d = dato_leido_q;
        if (state_q == c_R_RD && cnt_q == c_LAST) begin
            dato_leido_d = bus.bus_in;
        end
        error_rb_d = error_rb_q;
        if (w_start) begin
            error_rb_d = 1'b0;
        end else if (state_d == c_DONE) begin
            error_rb_d = (dato_leido_d != data_q);
        end
`else
        dato_leido_d = '0;
        error_rb_d   = 1'b0;
`endif
    end

    assign bus.bus_out    = bus_out_q;
    assign bus.bus_oe     = bus_oe_q;
    assign bus.cs_n       = cs_n_q;
    assign bus.a_d        = a_d_q;
    assign bus.wr_n       = wr_n_q;
    assign bus.rd_n       = rd_n_q;
    assign bus.listo      = listo_q;
    assign bus.dato_leido = dato_leido_q;
    assign bus.error_rb   = error_rb_q;
endmodule
`default_nettype wire

// File: tb/tb_rtc_secuencia_escribe.sv
`default_nettype none
// ============================================================================
// Module  : tb_rtc_secuencia_escribe
// Brief   : Randomized self-checking bench against a phase-arithmetic model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rtc_secuencia_escribe;
    localparam int T = 10;
`ifdef RTC_READBACK_EN
    localparam int NPH = 9;
`else
    localparam int NPH = 6;
`endif
    localparam int L = NPH * T;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] prev_leido = 8'h00;

    rtc_secuencia_escribe_if bus_if ();

    rtc_secuencia_escribe #(.T_FASE(T), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check_value({tag, "_cs_n"},   32'(bus_if.cs_n),    32'd1);
        check_value({tag, "_wr_n"},   32'(bus_if.wr_n),    32'd1);
        check_value({tag, "_rd_n"},   32'(bus_if.rd_n),    32'd1);
        check_value({tag, "_a_d"},    32'(bus_if.a_d),     32'd0);
        check_value({tag, "_bus_oe"}, 32'(bus_if.bus_oe),  32'd0);
        check_value({tag, "_bus_out"},32'(bus_if.bus_out), 32'd0);
        check_value({tag, "_listo"},  32'(bus_if.listo),   32'd0);
    endtask

    // Pin model: k edges after the start-sampling edge, phase = k / T.
    task automatic run_write(input logic [7:0] a, input logic [7:0] d,
                             input logic [7:0] rb, input int chg_k, input int stop_k);
        int p;
        logic [7:0] e_out;
        logic e_oe, e_cs, e_ad, e_wr, e_rd, e_ls;
        bus_if.direccion = a;
        bus_if.dato      = d;
        bus_if.bus_in    = rb;
        bus_if.arranque  = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k <= L + 20 && k <= stop_k; k++) begin
            if (k == chg_k) begin
                bus_if.dato      = 8'hFF ^ d ^ 8'(k);
                bus_if.direccion = a ^ 8'h5A;
                bus_if.bus_in    = ~rb;
            end
            if (k == L + 1) bus_if.arranque = 1'b0;
            p     = k / T;
            e_out = 8'h00; e_oe = 1'b0; e_cs = 1'b1; e_ad = 1'b0;
            e_wr  = 1'b1;  e_rd = 1'b1; e_ls = (k == L);
            if (k < L) begin
                e_cs = 1'b0;
                e_ad = (p >= 3);
                e_oe = (p < 6);
                e_wr = !(p == 1 || p == 4);
                e_rd = (p != 7);
                e_out = (p < 3) ? a : d;
            end
            check_value("cs_n",  32'(bus_if.cs_n),  32'(e_cs));
            check_value("a_d",   32'(bus_if.a_d),   32'(e_ad));
            check_value("bus_oe",32'(bus_if.bus_oe),32'(e_oe));
            check_value("wr_n",  32'(bus_if.wr_n),  32'(e_wr));
            check_value("rd_n",  32'(bus_if.rd_n),  32'(e_rd));
            check_value("listo", 32'(bus_if.listo), 32'(e_ls));
            if (e_oe || k >= L) check_value("bus_out", 32'(bus_if.bus_out), 32'(e_out));
`ifdef RTC_READBACK_EN
            if (chg_k < 8 * T) begin
                if (k >= 8 * T) check_value("dato_leido", 32'(bus_if.dato_leido), 32'(~rb));
                if (k >= L) check_value("error_rb", 32'(bus_if.error_rb), 32'(~rb != d));
            end else begin
                check_value("dato_leido", 32'(bus_if.dato_leido), 32'((k >= 8 * T) ? rb : prev_leido));
                check_value("error_rb", 32'(bus_if.error_rb), 32'((k >= L) ? (rb != d) : 1'b0));
            end
`else
            check_value("dato_leido", 32'(bus_if.dato_leido), 32'd0);
            check_value("error_rb",   32'(bus_if.error_rb),   32'd0);
`endif
            @(posedge clk); #1;
        end
`ifdef RTC_READBACK_EN
        if (stop_k >= L) prev_leido = (chg_k < 8 * T) ? ~rb : rb;
`endif
    endtask

    initial begin
        logic [7:0] ra, rd, rr;
        bus_if.arranque  = 1'b0;
        bus_if.direccion = 8'h00;
        bus_if.dato      = 8'h00;
        bus_if.bus_in    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset_held");
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            check_idle("after_reset");
        end

        // Directed write; dato changes to a different value mid-run.
        run_write(8'h21, 8'h45, 8'h44, 5, 1000);
        for (int i = 0; i < 60; i++) begin
            check_idle("no_retrigger");
            @(posedge clk); #1;
        end

        // Randomized writes, some with a matching read-back value.
        for (int n = 0; n < 8; n++) begin
            ra = 8'($urandom);
            rd = 8'($urandom);
            rr = ($urandom_range(0, 1) == 1) ? rd : 8'($urandom);
            run_write(ra, rd, rr, int'($urandom_range(1, L - 1)) + 1000, 1000);
            repeat ($urandom_range(0, 3)) begin
                check_idle("gap");
                @(posedge clk); #1;
            end
        end

        // Reset in the first cycle of D_WR.
        run_write(8'h21, 8'h45, 8'h45, 1000, 39);
        check_value("mid_wr_n_before", 32'(bus_if.wr_n), 32'd0);
        #2 rst = 1'b1;
        #1;
        check_value("mid_rst_cs_n",   32'(bus_if.cs_n),   32'd1);
        check_value("mid_rst_wr_n",   32'(bus_if.wr_n),   32'd1);
        check_value("mid_rst_bus_oe", 32'(bus_if.bus_oe), 32'd0);
        bus_if.arranque = 1'b0;
        prev_leido = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            check_idle("post_mid_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
